// File: rtl/adc_serial_responder_if.sv
// Serial link between the ADC reader (master) and the converter-side responder (slave).
interface adc_serial_responder_if;
  logic       ADC_SCLK;
  logic       ADC_CNVST;
  logic [1:0] ADC_OUT;

  modport master (output ADC_SCLK, output ADC_CNVST, input ADC_OUT);
  modport slave  (input ADC_SCLK, input ADC_CNVST, output ADC_OUT);
endinterface

// File: rtl/adc_serial_responder.sv
// Converter-side emulation of the dual-channel serial ADC: latches two samples at
// conversion start and shifts them MSB-first on ADC_OUT, timed by the reader's SCLK.
module adc_serial_responder #(
  parameter int BITS        = 12,
  parameter int LATENCY     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLOCK_50MHz,
  input  logic                   RESET_n,
  adc_serial_responder_if.slave  adc,
  input  logic [BITS-1:0]        SAMPLE0,
  input  logic [BITS-1:0]        SAMPLE1,
  output logic                   ACTIVE,
  output logic                   SAMPLE_TAKEN,
  output logic                   FRAME_DONE,
  output logic                   ABORTED,
  output logic [15:0]            FRAME_CNT
);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LAT   = 3'd1,
    SHIFT = 3'd2,
    TAIL  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cnvst_sync_r;
  logic                   sclk_prev_r;
  logic                   sclk_s;
  logic                   cnvst_s;
  logic                   fall_s;

  state_t                 state_r, state_next_s;
  logic [BITS-1:0]        sh0_r, sh0_next_s;
  logic [BITS-1:0]        sh1_r, sh1_next_s;
  logic [LAT_W-1:0]       lat_cnt_r, lat_cnt_next_s;
  logic [IDX_W-1:0]       bit_idx_r, bit_idx_next_s;
  logic [1:0]             adc_out_r, adc_out_next_s;
  logic                   active_r, active_next_s;
  logic                   sample_taken_r, sample_taken_next_s;
  logic                   frame_done_r, frame_done_next_s;
  logic                   aborted_r, aborted_next_s;
  logic [15:0]            frame_cnt_r, frame_cnt_next_s;

  assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
  assign cnvst_s = cnvst_sync_r[SYNC_STAGES-1];
  assign fall_s  = sclk_prev_r & ~sclk_s;

  // Synchroniser chains; reset parks them at the idle line levels so no false edge follows reset.
  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      sclk_sync_r  <= {SYNC_STAGES{1'b0}};
      cnvst_sync_r <= {SYNC_STAGES{1'b1}};
      sclk_prev_r  <= 1'b0;
    end else begin
      sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], adc.ADC_SCLK};
      cnvst_sync_r <= {cnvst_sync_r[SYNC_STAGES-2:0], adc.ADC_CNVST};
      sclk_prev_r  <= sclk_s;
    end
  end

  // Frame sequencing: every protocol action is gated by a detected SCLK fall.
  always_comb begin
    state_next_s        = state_r;
    sh0_next_s          = sh0_r;
    sh1_next_s          = sh1_r;
    lat_cnt_next_s      = lat_cnt_r;
    bit_idx_next_s      = bit_idx_r;
    adc_out_next_s      = adc_out_r;
    active_next_s       = active_r;
    sample_taken_next_s = 1'b0;
    frame_done_next_s   = 1'b0;
    aborted_next_s      = 1'b0;
    frame_cnt_next_s    = frame_cnt_r;
    if (fall_s) begin
      case (state_r)
        IDLE: begin
          adc_out_next_s = 2'b00;
          if (!cnvst_s) begin
            sh0_next_s          = SAMPLE0;
            sh1_next_s          = SAMPLE1;
            sample_taken_next_s = 1'b1;
            active_next_s       = 1'b1;
            lat_cnt_next_s      = {LAT_W{1'b0}};
            state_next_s        = LAT;
          end else begin
            state_next_s = IDLE;
          end
        end
        LAT: begin
          if (cnvst_s) begin
            adc_out_next_s = 2'b00;
            active_next_s  = 1'b0;
            aborted_next_s = 1'b1;
            state_next_s   = IDLE;
          end else if (lat_cnt_r == LAT_LAST) begin
            adc_out_next_s = {sh1_r[BITS-1], sh0_r[BITS-1]};
            bit_idx_next_s = IDX_W'(BITS - 2);
            state_next_s   = SHIFT;
          end else begin
            lat_cnt_next_s = lat_cnt_r + {{(LAT_W-1){1'b0}}, 1'b1};
          end
        end
        SHIFT: begin
          if (cnvst_s) begin
            adc_out_next_s = 2'b00;
            active_next_s  = 1'b0;
            aborted_next_s = 1'b1;
            state_next_s   = IDLE;
          end else begin
            adc_out_next_s = {sh1_r[bit_idx_r], sh0_r[bit_idx_r]};
            if (bit_idx_r == {IDX_W{1'b0}}) begin
              state_next_s = TAIL;
            end else begin
              bit_idx_next_s = bit_idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        TAIL: begin
          adc_out_next_s    = 2'b00;
          frame_done_next_s = 1'b1;
          frame_cnt_next_s  = frame_cnt_r + 16'd1;
          state_next_s      = WAIT;
        end
        WAIT: begin
          if (cnvst_s) begin
            active_next_s = 1'b0;
            state_next_s  = IDLE;
          end else begin
            state_next_s = WAIT;
          end
        end
        default: begin
          adc_out_next_s = 2'b00;
          active_next_s  = 1'b0;
          state_next_s   = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50MHz) begin
    if (!RESET_n) begin
      state_r        <= IDLE;
      sh0_r          <= {BITS{1'b0}};
      sh1_r          <= {BITS{1'b0}};
      lat_cnt_r      <= {LAT_W{1'b0}};
      bit_idx_r      <= {IDX_W{1'b0}};
      adc_out_r      <= 2'b00;
      active_r       <= 1'b0;
      sample_taken_r <= 1'b0;
      frame_done_r   <= 1'b0;
      aborted_r      <= 1'b0;
      frame_cnt_r    <= 16'd0;
    end else begin
      state_r        <= state_next_s;
      sh0_r          <= sh0_next_s;
      sh1_r          <= sh1_next_s;
      lat_cnt_r      <= lat_cnt_next_s;
      bit_idx_r      <= bit_idx_next_s;
      adc_out_r      <= adc_out_next_s;
      active_r       <= active_next_s;
      sample_taken_r <= sample_taken_next_s;
      frame_done_r   <= frame_done_next_s;
      aborted_r      <= aborted_next_s;
      frame_cnt_r    <= frame_cnt_next_s;
    end
  end

  assign adc.ADC_OUT  = adc_out_r;
  assign ACTIVE       = active_r;
  assign SAMPLE_TAKEN = sample_taken_r;
  assign FRAME_DONE   = frame_done_r;
  assign ABORTED      = aborted_r;
  assign FRAME_CNT    = frame_cnt_r;
endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Synthesizable emulation of the board's dual-channel serial ADC, seen from the converter side.
- Takes two parallel 12-bit samples and serves them on ADC_OUT[1:0] in the framing our ADC reader expects.
- Driven by the reader's ADC_SCLK and ADC_CNVST.
- Used as a drop-in when the physical ADC is absent, and as a bench stimulus source for the reader.

Parameters:
- BITS, 12, sample width per channel; frame shifts BITS bits MSB-first.
- LATENCY, 3, SCLK falling edges between conversion start and the edge that drives the MSB.
- SYNC_STAGES, 2, flip-flop stages synchronising ADC_SCLK and ADC_CNVST into the CLOCK_50MHz domain (minimum 2).

Ports:
- CLOCK_50MHz  in  1  system clock; all logic on its rising edge.
- RESET_n  in  1  synchronous, active-low reset.
- ADC_SCLK  in  1  serial clock from the reader (≥8 CLOCK_50MHz cycles per period, ≥4 per phase).
- ADC_CNVST  in  1  from the reader; 1 = no conversion, 0 = conversion/frame in progress.
- SAMPLE0  in  BITS  channel 0 value, latched at conversion start.
- SAMPLE1  in  BITS  channel 1 value, latched at conversion start.
- ADC_OUT  out  2  serial data; bit0 = channel 0, bit1 = channel 1.
- ACTIVE  out  1  high from conversion start until the frame ends or aborts.
- SAMPLE_TAKEN  out  1  one-cycle pulse when SAMPLE0/1 are latched.
- FRAME_DONE  out  1  one-cycle pulse when bit 0 has been driven and held through its sampling edge.
- ABORTED  out  1  one-cycle pulse when ADC_CNVST rises before bit 0 is driven.
- FRAME_CNT  out  16  completed frames, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (RESET_n low at a clock edge):
  - ADC_OUT=2'b00; ACTIVE=0; SAMPLE_TAKEN=0; FRAME_DONE=0; ABORTED=0; FRAME_CNT=0.
  - Shadow registers cleared; sync chains filled with ADC_SCLK=0, ADC_CNVST=1; state IDLE.
  - Reset mid-frame abandons the frame with no ABORTED pulse.
- Synchronisation and edge detect:
  - sclk_s and cnvst_s are the last stages of the sync chains.
  - A falling edge (fall) is registered when the previous sclk_s = 1 and the current sclk_s = 0.
  - All protocol actions occur only in the cycle a fall is detected.
- IDLE:
  - On fall with cnvst_s = 0: latch SAMPLE0/1 into the shadows, pulse SAMPLE_TAKEN, ACTIVE <= 1, lat_cnt <= 0, go to LAT.
  - ADC_OUT holds 00.
- LAT:
  - On each fall, lat_cnt increments.
  - On the LATENCY-th fall after start: drive ADC_OUT = {sh1[BITS-1], sh0[BITS-1]}, bit_idx <= BITS-2, go to SHIFT.
  - With LATENCY=3, the MSB is stable at the reader's 4th rising SCLK after it pulled CNVST low.
- SHIFT:
  - On each fall, drive {sh1[bit_idx], sh0[bit_idx]} and decrement bit_idx.
  - After driving bit 0, go to TAIL.
- TAIL:
  - On the next fall, bit 0 has been sampled: ADC_OUT <= 00, pulse FRAME_DONE, FRAME_CNT++, go to WAIT.
- WAIT:
  - Stays until cnvst_s = 1, then ACTIVE <= 0 and go to IDLE.
  - A new conversion requires ADC_CNVST high for at least one fall, or a fresh start detected from IDLE.
- Abort:
  - Condition: in LAT or SHIFT, a fall occurs with cnvst_s = 1.
  - Response: ADC_OUT <= 00, ACTIVE <= 0, pulse ABORTED, go to IDLE; FRAME_CNT unchanged.
- Simultaneous events and timing:
  - SAMPLE0/1 changing in the same cycle as the start fall: the value present that cycle is latched.
  - Inputs changing mid-frame do not affect the frame in flight.
  - ADC_OUT changes SYNC_STAGES+1 clock cycles after the true SCLK falling edge. For a 4-cycle half period, data settles at least 1 cycle before the reader's rising edge.
- Reader framing (for reference by the verifier):
  - The reader keeps the top 8 bits.
  - The full BITS bits are always shifted.

Test Plan:
1. Single frame, reader-style master with SCLK toggling every 4 clocks; SAMPLE0=12'hA5C, SAMPLE1=12'h3F0; CNVST pulled low.
   - Reader captures DATA_AD0=8'hA5, DATA_AD1=8'h3F.
   - SAMPLE_TAKEN pulses once; FRAME_DONE pulses once; FRAME_CNT=1.
   - Bit-level capture of ADC_OUT is 0xA5C / 0x3F0.
2. Back-to-back frames with SAMPLE0 changed to 12'h001 during frame 1.
   - Frame 1 still yields 12'hA5C; frame 2 yields 12'h001.
   - FRAME_CNT=2; ACTIVE drops between frames.
3. Abort: CNVST driven high after the 5th data bit.
   - ABORTED pulses once; ADC_OUT=00 from the next fall.
   - FRAME_CNT unchanged; next frame is served correctly.
4. Reset mid-SHIFT (RESET_n low one cycle).
   - All outputs return to reset values; no ABORTED or FRAME_DONE pulse.
   - Next conversion start is served normally.
5. Wrap: preload by running 65536 frames (or force FRAME_CNT=16'hFFFF).
   - One more frame gives FRAME_CNT=0.
6. Extremes: SAMPLE0=12'hFFF, SAMPLE1=12'h000.
   - ADC_OUT[0] is high for exactly 12 falls; ADC_OUT[1] stays low throughout.
   - Reader gets 8'hFF / 8'h00.
